// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolution: checks the IF-stage BTB prediction against the actual
// outcome, trains the BTB, redirects IF on mispredict and keeps saturating statistics.
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  input  logic                 mem_is_branch,
  input  logic                 mem_is_jump,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_br_taken,
  input  logic [31:0]          mem_target,
  input  logic                 mem_pred_hit,
  input  logic                 mem_pred_taken,
  input  logic [31:0]          mem_pred_target,
  input  logic                 if_ready,
  input  logic                 clr_stats,
  output logic [31:0]          btb_mem_pc,
  output logic [31:0]          btb_target_in,
  output logic                 btb_replace,
  output logic                 btb_update,
  output logic                 btb_branch_result,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic                 stall_mem,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state;
  logic        resolve;
  logic        ctrl;
  logic        act;
  logic        pred;
  logic        mispredict;
  logic        alloc;
  logic        train;
  logic [31:0] correct_pc;

  // mem_* inputs are only looked at while no redirect is outstanding.
  assign resolve    = (state == IDLE) & mem_valid;
  assign ctrl       = mem_is_branch | mem_is_jump;
  assign act        = mem_is_jump | (mem_is_branch & mem_br_taken);
  assign pred       = mem_pred_hit & mem_pred_taken;
  assign mispredict = ctrl ? ((act != pred) | (act & pred & (mem_pred_target != mem_target)))
                           : pred;
  assign correct_pc = act ? mem_target : mem_pc + 32'd4;
  assign alloc      = ctrl & ~mem_pred_hit & act;
  assign train      = ctrl & mem_pred_hit;

  assign stall_mem  = (state == REDIRECT);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      btb_mem_pc        <= '0;
      btb_target_in     <= '0;
      btb_replace       <= 1'b0;
      btb_update        <= 1'b0;
      btb_branch_result <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      flush             <= 1'b0;
    end else begin
      btb_replace <= resolve & alloc;
      btb_update  <= resolve & train;
      flush       <= 1'b0;

      if (resolve && (alloc || train)) begin
        btb_mem_pc        <= mem_pc;
        btb_target_in     <= mem_target;
        btb_branch_result <= act;
      end

      case (state)
        IDLE: begin
          if (resolve && mispredict) begin
            state          <= REDIRECT;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= correct_pc;
          end
        end
        REDIRECT: begin
          if (if_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (clr_stats) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve) begin
      if (ctrl && (branch_count != '1))
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the unit.
module tb_branch_resolve_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid, mem_is_branch, mem_is_jump, mem_br_taken;
  logic [31:0]   mem_pc, mem_target, mem_pred_target;
  logic          mem_pred_hit, mem_pred_taken, if_ready, clr_stats;
  logic [31:0]   btb_mem_pc, btb_target_in, redirect_pc;
  logic          btb_replace, btb_update, btb_branch_result;
  logic          redirect_valid, flush, stall_mem;
  logic [CW-1:0] branch_count, mispredict_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state: what each output should read after the next edge.
  logic        m_redir, m_flush, m_rv, m_rep, m_upd, m_bres;
  logic [31:0] m_rpc, m_bpc, m_btgt;
  int          m_bc, m_mc;

  branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_is_branch(mem_is_branch), .mem_is_jump(mem_is_jump),
    .mem_pc(mem_pc), .mem_br_taken(mem_br_taken), .mem_target(mem_target),
    .mem_pred_hit(mem_pred_hit), .mem_pred_taken(mem_pred_taken),
    .mem_pred_target(mem_pred_target), .if_ready(if_ready), .clr_stats(clr_stats),
    .btb_mem_pc(btb_mem_pc), .btb_target_in(btb_target_in), .btb_replace(btb_replace),
    .btb_update(btb_update), .btb_branch_result(btb_branch_result),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stall_mem(stall_mem), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [109:0] dut_vec();
    return {btb_mem_pc, btb_target_in, btb_replace, btb_update, btb_branch_result,
            redirect_valid, redirect_pc, flush, stall_mem, branch_count, mispredict_count};
  endfunction

  function automatic logic [109:0] exp_vec();
    return {m_bpc, m_btgt, m_rep, m_upd, m_bres, m_rv, m_rpc, m_flush, m_redir,
            CW'(m_bc), CW'(m_mc)};
  endfunction

  task automatic model_reset();
    m_redir = 0; m_flush = 0; m_rv = 0; m_rep = 0; m_upd = 0; m_bres = 0;
    m_rpc = 0; m_bpc = 0; m_btgt = 0; m_bc = 0; m_mc = 0;
  endtask

  // Applies the architectural rules to the inputs presented this cycle.
  task automatic model_step();
    bit is_ctrl, taken, predicted, wrong, was_redir;
    logic [31:0] fix_pc;
    was_redir = m_redir;
    m_flush = 0; m_rep = 0; m_upd = 0;
    if (was_redir) begin
      if (if_ready) begin m_redir = 0; m_rv = 0; end
    end else if (mem_valid) begin
      is_ctrl   = mem_is_branch || mem_is_jump;
      taken     = mem_is_jump || (mem_is_branch && mem_br_taken);
      predicted = mem_pred_hit && mem_pred_taken;
      if (is_ctrl) wrong = (taken != predicted) || (taken && mem_pred_target != mem_target);
      else         wrong = predicted;
      fix_pc = taken ? mem_target : 32'(64'(mem_pc) + 64'd4);
      if (is_ctrl && mem_pred_hit) m_upd = 1;
      if (is_ctrl && !mem_pred_hit && taken) m_rep = 1;
      if (m_upd || m_rep) begin m_bpc = mem_pc; m_btgt = mem_target; m_bres = taken; end
      if (wrong) begin m_redir = 1; m_flush = 1; m_rv = 1; m_rpc = fix_pc; end
    end
    if (clr_stats) begin
      m_bc = 0; m_mc = 0;
    end else if (!was_redir && mem_valid) begin
      if ((mem_is_branch || mem_is_jump) && m_bc < CMAX) m_bc++;
      if (wrong && m_mc < CMAX) m_mc++;
    end
  endtask

  task automatic drive(input bit v, input bit br, input bit jmp, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tgt, input bit hit, input bit ptk,
                       input logic [31:0] ptgt, input bit rdy, input bit clr);
    mem_valid = v; mem_is_branch = br; mem_is_jump = jmp; mem_pc = pc; mem_br_taken = tk;
    mem_target = tgt; mem_pred_hit = hit; mem_pred_taken = ptk; mem_pred_target = ptgt;
    if_ready = rdy; clr_stats = clr;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (dut_vec() !== 110'd0) begin
      n_fail++; $display("FAIL reset_state: got %h required 0", dut_vec());
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL after_reset: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_cold_taken();
    drive(1, 1, 0, 32'h100, 1, 32'h140, 0, 0, 32'h0, 0, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL cold_taken: got %h required %h", dut_vec(), exp_vec());
    end
    n_cmp++;
    if ({btb_replace, btb_update, flush, redirect_valid, redirect_pc, btb_mem_pc, btb_target_in,
         branch_count, mispredict_count} !== {4'b1011, 32'h140, 32'h100, 32'h140, 4'd1, 4'd1}) begin
      n_fail++; $display("FAIL cold_taken_fields: rpc=%h bpc=%h tgt=%h bc=%0d mc=%0d required 140/100/140/1/1",
                         redirect_pc, btb_mem_pc, btb_target_in, branch_count, mispredict_count);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || stall_mem !== 1'b0) begin
      n_fail++; $display("FAIL cold_accept: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_correct_pred();
    drive(1, 1, 0, 32'h100, 1, 32'h140, 1, 1, 32'h140, 0, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() ||
        {btb_update, btb_replace, btb_branch_result, flush, redirect_valid, stall_mem} !== 6'b101000 ||
        mispredict_count !== 4'd1) begin
      n_fail++; $display("FAIL correct_pred: got %h required %h", dut_vec(), exp_vec());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || btb_update !== 1'b0) begin
      n_fail++; $display("FAIL update_pulse: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_nt_wrap_stall();
    drive(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h1234_5678, 1, 1, 32'h1234_5678, 0, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || redirect_pc !== 32'h0 ||
        {btb_update, btb_branch_result, flush, stall_mem} !== 4'b1011) begin
      n_fail++; $display("FAIL nt_wrap: rpc=%h got %h required %h", redirect_pc, dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(i != 1, 0, 1, 32'h40 + 32'(i), 0, 32'h80, 0, 0, 0, 0, 0);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec() || {redirect_valid, stall_mem, flush} !== 3'b110) begin
        n_fail++; $display("FAIL redirect_hold%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    drive(1, 0, 1, 32'h40, 0, 32'h80, 0, 0, 0, 1, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || {redirect_valid, stall_mem} !== 2'b00 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL redirect_accept: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_false_hit();
    drive(1, 0, 0, 32'h200, 0, 32'h999, 1, 1, 32'h300, 0, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || redirect_pc !== 32'h204 || {btb_replace, btb_update} !== 2'b00) begin
      n_fail++; $display("FAIL false_hit: got %h required %h", dut_vec(), exp_vec());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL false_hit_accept: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    for (int i = 0; i < 34; i++) begin
      drive(1, 0, 1, 32'h1000 + 32'(i * 4), 0, 32'h2000 + 32'(i * 8), 0, 0, 0, 1, 0);
      cycle();
    end
    n_cmp++;
    if (dut_vec() !== exp_vec() || branch_count !== 4'hF || mispredict_count !== 4'hF) begin
      n_fail++; $display("FAIL saturate: bc=%0d mc=%0d required 15/15", branch_count, mispredict_count);
    end
    drive(1, 0, 1, 32'h3000, 0, 32'h4000, 0, 0, 0, 0, 1);
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || branch_count !== 4'h0 || mispredict_count !== 4'h0) begin
      n_fail++; $display("FAIL clr_priority: bc=%0d mc=%0d required 0/0", branch_count, mispredict_count);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, tgt,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    drive(1, 0, 1, 32'h500, 0, 32'h600, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    n_cmp++;
    if (redirect_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pre_reset_redirect: got %h required %h", dut_vec(), exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 110'd0) begin
      n_fail++; $display("FAIL async_reset: got %h required 0", dut_vec());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec() || stall_mem !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    test_reset();
    test_cold_taken();
    test_correct_pred();
    test_nt_wrap_stall();
    test_false_hit();
    test_saturation();
    test_back_to_back_random();
    test_reset_mid_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- MEM-stage branch resolution block, directly upstream of the branch target buffer / history table.
- Compares the actual outcome of each MEM-stage instruction with the BTB prediction carried down from IF.
- Drives the BTB replace/update write port, raises a flush/redirect to IF on mispredict and holds it until IF accepts.
- Keeps saturating branch and mispredict counters.

Parameters:
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a valid instruction this cycle
mem_is_branch  in  1  instruction is a conditional branch
mem_is_jump  in  1  instruction is jal/jalr
mem_pc  in  32  PC of MEM instruction
mem_br_taken  in  1  comparator outcome (meaningful only for branches)
mem_target  in  32  ALU-computed target
mem_pred_hit  in  1  BTB hit seen in IF for this instruction
mem_pred_taken  in  1  BTB prediction seen in IF
mem_pred_target  in  32  BTB target used in IF
if_ready  in  1  IF accepts redirect this cycle
clr_stats  in  1  synchronous counter clear
btb_mem_pc  out  32  PC to BTB (tag/lookup)
btb_target_in  out  32  target to BTB on allocate
btb_replace  out  1  allocate BTB entry (1-cycle pulse)
btb_update  out  1  train history of hit entry (1-cycle pulse)
btb_branch_result  out  1  actual taken/not-taken for training
redirect_valid  out  1  redirect request to IF
redirect_pc  out  32  corrected fetch PC
flush  out  1  squash IF/ID/EX (1-cycle pulse)
stall_mem  out  1  MEM must hold while redirect pending
branch_count  out  CNT_WIDTH  resolved control instructions
mispredict_count  out  CNT_WIDTH  mispredicts

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; every output 0, including counters. A reset during REDIRECT drops the redirect immediately.
- Resolution occurs when state==IDLE && mem_valid. In REDIRECT, mem_* inputs are ignored.
- Derived terms:
  - ctrl = is_branch|is_jump
  - act = is_jump | (is_branch & br_taken)
  - pred = pred_hit & pred_taken
- Mispredict:
  - ctrl: (act != pred) | (act & pred & pred_target != mem_target)
  - non-ctrl: pred (false BTB hit)
- Correct PC: act ? mem_target : mem_pc+4. The +4 wraps modulo 2^32.
- BTB outputs are registered: visible the cycle after resolution, deasserted the following cycle unless re-driven.
  - btb_replace=1 when ctrl & !pred_hit & act.
  - btb_update=1 when ctrl & pred_hit.
  - btb_mem_pc=mem_pc; btb_target_in=mem_target; btb_branch_result=act. These hold their last value when no pulse is issued.
  - replace and update are never both 1.
- FSM IDLE -> REDIRECT on resolution with mispredict.
  - First REDIRECT cycle: flush=1, redirect_valid=1, redirect_pc=correct PC (registered).
  - While in REDIRECT: redirect_valid and redirect_pc hold, flush=0, stall_mem=1.
  - REDIRECT -> IDLE on a cycle with if_ready=1 (accept). An accept in the first cycle gives a 1-cycle redirect.
  - After accept: redirect_valid=0, stall_mem=0. redirect_pc holds its last value.
- stall_mem = (state==REDIRECT), combinational from state.
- Counters:
  - branch_count +1 per resolution with ctrl.
  - mispredict_count +1 per resolution with mispredict.
  - Both saturate at all-ones, no wrap.
  - clr_stats zeroes both and has priority over an increment in the same cycle.
- mem_is_branch & mem_is_jump both 1 is illegal input. Treat it as jump.
- Correct prediction: no flush, no redirect, no stall. Back-to-back resolutions are allowed every cycle in IDLE.

Test Plan:
- Reset: rst_n low mid-REDIRECT with redirect_valid=1 -> all outputs 0 asynchronously; IDLE after release.
- Cold taken branch: pc=0x100, is_branch, br_taken=1, target=0x140, pred_hit=0 -> next cycle btb_replace=1, btb_mem_pc=0x100, btb_target_in=0x140, flush=1, redirect_pc=0x140; branch_count=1, mispredict_count=1.
- Correct prediction: pc=0x100, hit, pred_taken=1, pred_target=0x140, actual taken to 0x140 -> btb_update=1, btb_branch_result=1, flush=0, redirect_valid=0, mispredict_count unchanged.
- Not-taken mispredict with IF stall: pc=0xFFFFFFFC, hit, pred_taken=1, br_taken=0 -> redirect_pc=0x00000000 (wrap), btb_update=1, btb_branch_result=0. Hold if_ready=0 for 3 cycles -> redirect_valid=1 and stall_mem=1 held, flush only in first cycle, mem_valid pulses ignored (counters unchanged); if_ready=1 -> IDLE next cycle.
- False hit on non-ctrl: pc=0x200, hit, pred_taken=1 -> redirect_pc=0x204, no replace/update, mispredict_count+1, branch_count unchanged.
- Counter saturation/clear: CNT_WIDTH=4, 17 mispredicted jumps -> both counters 15; clr_stats with a simultaneous resolution -> both 0.
